// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - miss-handling sequencer for a direct-mapped data cache
module dcache_ctrl #(
   parameter int TAG_BITS    = 18,
   parameter int INDEX_BITS  = 10,
   parameter int OFFSET_BITS = 4,
   parameter int BLOCK_SIZE  = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_wr,
   input  logic [31:0]           cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_done,
   output logic                  cache_en,
   output logic                  cache_rd,
   output logic                  cache_wr,
   output logic                  cache_ld,
   output logic [31:0]           cache_addr,
   output logic [31:0]           cache_dataIn,
   output logic [BLOCK_SIZE-1:0] cache_blkIn,
   input  logic [31:0]           cache_dataOut,
   input  logic                  cache_hit,
   input  logic                  cache_miss,
   input  logic                  cache_evict,
   input  logic [BLOCK_SIZE-1:0] cache_blkOut,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [31:0]           mem_addr,
   output logic [BLOCK_SIZE-1:0] mem_wdata,
   input  logic [BLOCK_SIZE-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt,
   output logic                  err
);
   localparam int LINES = 1 << INDEX_BITS;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_CHECK, S_WB, S_FILL, S_LOAD, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [31:0]             addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    wr_q, wr_d;
   logic                    replay_q, replay_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [BLOCK_SIZE-1:0]   blk_q, blk_d;
   logic                    err_q, err_d;
   logic [31:0]             hit_cnt_q, miss_cnt_q;
   logic                    hit_inc, miss_inc, shadow_wr;
   logic [LINES-1:0]        valid_q;
   logic [TAG_BITS-1:0]     tag_mem [LINES];

   logic [INDEX_BITS-1:0]   index;
   logic [TAG_BITS-1:0]     tag;
   logic [TAG_BITS-1:0]     victim_tag;
   logic [31:0]             blk_addr;

   assign index      = addr_q[OFFSET_BITS +: INDEX_BITS];
   assign tag        = addr_q[OFFSET_BITS + INDEX_BITS +: TAG_BITS];
   // Tag entries are never reset; an invalid line reads as tag 0 instead.
   assign victim_tag = valid_q[index] ? tag_mem[index] : '0;
   assign blk_addr   = {tag, index, {OFFSET_BITS{1'b0}}};

   assign cpu_rdata = rdata_q;
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;
   assign err       = err_q;

   // Next-state and control outputs; cache/memory controls decode from state.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wr_d         = wr_q;
      replay_d     = replay_q;
      rdata_d      = rdata_q;
      blk_d        = blk_q;
      err_d        = err_q;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      shadow_wr    = 1'b0;
      cpu_done     = 1'b0;
      cache_en     = 1'b0;
      cache_rd     = 1'b0;
      cache_wr     = 1'b0;
      cache_ld     = 1'b0;
      cache_addr   = '0;
      cache_dataIn = '0;
      cache_blkIn  = '0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               wr_d    = cpu_wr;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            cache_en     = 1'b1;
            cache_rd     = ~wr_q;
            cache_wr     = wr_q;
            cache_addr   = addr_q;
            cache_dataIn = wdata_q;
            state_d      = S_CHECK;
         end
         S_CHECK: begin
            if (cache_hit) begin
               rdata_d = cache_dataOut;
               hit_inc = ~replay_q;
               state_d = S_DONE;
            end else if (cache_miss) begin
               if (replay_q) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = S_DONE;
               end else begin
                  miss_inc = 1'b1;
                  blk_d    = cache_blkOut;
                  state_d  = cache_evict ? S_WB : S_FILL;
               end
            end else begin
               // Neither status flag: reissue the lookup rather than guess.
               state_d = S_LOOKUP;
            end
         end
         S_WB: begin
            mem_wr    = 1'b1;
            mem_addr  = {victim_tag, index, {OFFSET_BITS{1'b0}}};
            mem_wdata = blk_q;
            if (mem_ack) state_d = S_FILL;
         end
         S_FILL: begin
            mem_rd   = 1'b1;
            mem_addr = blk_addr;
            if (mem_ack) begin
               blk_d   = mem_rdata;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cache_en    = 1'b1;
            cache_ld    = 1'b1;
            cache_addr  = blk_addr;
            cache_blkIn = blk_q;
            shadow_wr   = 1'b1;
            replay_d    = 1'b1;
            state_d     = S_LOOKUP;
         end
         S_DONE: begin
            cpu_done = 1'b1;
            replay_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, latched request, captured blocks, counters and shadow valid bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         replay_q   <= 1'b0;
         rdata_q    <= '0;
         blk_q      <= '0;
         err_q      <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         valid_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         replay_q <= replay_d;
         rdata_q  <= rdata_d;
         blk_q    <= blk_d;
         err_q    <= err_d;
         if (hit_inc && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (miss_inc && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
         if (shadow_wr) valid_q[index] <= 1'b1;
      end
   end

   // Shadow tag storage, written when a fetched block is loaded.
   always_ff @(posedge clk) begin
      if (shadow_wr) tag_mem[index] <= tag;
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req, cpu_wr;
   logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
   logic         cpu_done;
   logic         cache_en, cache_rd, cache_wr, cache_ld;
   logic [31:0]  cache_addr, cache_dataIn, cache_dataOut;
   logic [511:0] cache_blkIn, cache_blkOut;
   logic         cache_hit, cache_miss, cache_evict;
   logic         mem_rd, mem_wr, mem_ack;
   logic [31:0]  mem_addr;
   logic [511:0] mem_wdata, mem_rdata;
   logic [31:0]  hit_cnt, miss_cnt;
   logic         err;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        chk_rd;
      logic [31:0] rdata;
      logic        err;
   } cpu_exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] w1;
   } mem_exp_t;

   cpu_exp_t exp_cpu[$];
   mem_exp_t exp_mem[$];

   int  mem_delay = 0;
   int  mem_req_cnt = 0;
   int  done_cnt = 0;
   logic force_miss = 1'b0;

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
      .cache_en(cache_en), .cache_rd(cache_rd), .cache_wr(cache_wr), .cache_ld(cache_ld),
      .cache_addr(cache_addr), .cache_dataIn(cache_dataIn), .cache_blkIn(cache_blkIn),
      .cache_dataOut(cache_dataOut), .cache_hit(cache_hit), .cache_miss(cache_miss),
      .cache_evict(cache_evict), .cache_blkOut(cache_blkOut),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mk_blk(input logic [31:0] a);
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[i*32 +: 32] = a + 32'(i);
      return b;
   endfunction

   // Behavioural data_cache: controls sampled in cycle N, status driven for cycle N+1.
   logic [17:0]  m_tag   [1024];
   logic         m_valid [1024];
   logic         m_dirty [1024];
   logic [511:0] m_data  [1024];
   initial begin
      logic c_en, c_wr, c_ld;
      logic [31:0] c_addr, c_din;
      logic [511:0] c_blk;
      int idx, off;
      for (int i = 0; i < 1024; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
      end
      cache_hit = 0; cache_miss = 0; cache_evict = 0; cache_dataOut = 0; cache_blkOut = 0;
      forever begin
         @(negedge clk);
         c_en = cache_en; c_wr = cache_wr; c_ld = cache_ld;
         c_addr = cache_addr; c_din = cache_dataIn; c_blk = cache_blkIn;
         @(posedge clk); #1;
         cache_hit = 0; cache_miss = 0; cache_evict = 0;
         if (c_en) begin
            idx = int'(c_addr[13:4]);
            off = int'(c_addr[3:0]);
            if (c_ld) begin
               m_data[idx] = c_blk; m_tag[idx] = c_addr[31:14];
               m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
            end else if (m_valid[idx] && m_tag[idx] == c_addr[31:14] && !force_miss) begin
               cache_hit = 1'b1;
               cache_dataOut = m_data[idx][off*32 +: 32];
               if (c_wr) begin
                  m_data[idx][off*32 +: 32] = c_din;
                  m_dirty[idx] = 1'b1;
               end
            end else begin
               cache_miss = 1'b1;
               cache_evict = m_valid[idx] && m_dirty[idx];
               cache_blkOut = m_data[idx];
            end
         end
      end
   end

   // Memory responder: checks each new request against the scoreboard, acks after mem_delay.
   initial begin
      int wait_cnt;
      logic busy;
      mem_exp_t e;
      mem_ack = 0; mem_rdata = '0; wait_cnt = 0; busy = 0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (rst && (mem_rd || mem_wr)) begin
            if (!busy) begin
               busy = 1'b1; wait_cnt = 0; mem_req_cnt++;
               checks++;
               assert (exp_mem.size() != 0) else begin
                  failures++;
                  $error("FAIL mem_unexpected observed=%h expected=none", mem_addr);
               end
               if (exp_mem.size() != 0) begin
                  e = exp_mem.pop_front();
                  chk("mem_is_wr", 32'(mem_wr), 32'(e.wr));
                  chk("mem_addr", mem_addr, e.addr);
                  if (e.wr) chk("wb_word1", mem_wdata[63:32], e.w1);
               end
            end
            if (wait_cnt >= mem_delay) begin
               mem_ack = 1'b1; mem_rdata = mk_blk(mem_addr); busy = 1'b0;
            end else begin
               wait_cnt++;
            end
         end else begin
            busy = 1'b0; wait_cnt = 0;
         end
      end
   end

   // Output monitor: CPU completions against scoreboard, pulse width, mem exclusivity.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      cpu_exp_t e;
      if (rst && (mem_rd || mem_wr)) chk("mem_rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
      if (rst && cpu_done) begin
         done_cnt++;
         chk("done_one_cycle", 32'(prev_done), 32'd0);
         chk("done_expected", 32'(exp_cpu.size() != 0), 32'd1);
         if (exp_cpu.size() != 0) begin
            e = exp_cpu.pop_front();
            if (e.chk_rd) chk("cpu_rdata", cpu_rdata, e.rdata);
            chk("err_at_done", 32'(err), 32'(e.err));
         end
      end
      prev_done = cpu_done;
   end

   task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err,
                         output int lat);
      cpu_exp_t e;
      @(negedge clk);
      cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
      e.chk_rd = chk_rd; e.rdata = exp_rd; e.err = exp_err;
      exp_cpu.push_back(e);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_wr = ~wr;
         end
      end while (!cpu_done && lat < 300);
      if (!cpu_done) chk("cpu_done_timeout", 32'd0, 32'd1);
      cpu_req = 1'b0;
   endtask

   initial begin
      int lat, base, n, d0;
      mem_exp_t m;
      rst = 1'b0; cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_done", 32'(cpu_done), 32'd0);
      chk("rst_cache_en", 32'(cache_en), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      rst = 1'b1;

      // Cold load miss: fill line 1 with words 16..31, replay returns word 22.
      m.wr = 0; m.addr = 32'h10; m.w1 = 0; exp_mem.push_back(m);
      base = mem_req_cnt;
      do_req(1'b0, 32'h16, 32'h0, 1'b1, 32'd22, 1'b0, lat);
      chk("miss_latency", 32'(lat), 32'd7);
      chk("miss_cnt_1", miss_cnt, 32'd1);
      chk("hit_cnt_0", hit_cnt, 32'd0);
      chk("miss_mem_reqs", 32'(mem_req_cnt - base), 32'd1);

      // Repeat load hits with three-cycle latency.
      base = mem_req_cnt;
      do_req(1'b0, 32'h16, 32'h0, 1'b1, 32'd22, 1'b0, lat);
      chk("hit_latency", 32'(lat), 32'd3);
      chk("hit_cnt_1", hit_cnt, 32'd1);

      // Store hit then load back.
      do_req(1'b1, 32'h11, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, lat);
      chk("store_hit_latency", 32'(lat), 32'd3);
      do_req(1'b0, 32'h11, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, lat);
      chk("hit_no_mem", 32'(mem_req_cnt - base), 32'd0);
      chk("hit_cnt_3", hit_cnt, 32'd3);

      // Conflicting store: dirty victim written back, tag-1 block fetched, store replayed.
      m.wr = 1; m.addr = 32'h10; m.w1 = 32'hFFFF_FFFF; exp_mem.push_back(m);
      m.wr = 0; m.addr = 32'h4010; m.w1 = 0; exp_mem.push_back(m);
      do_req(1'b1, 32'h4011, 32'h1234_5678, 1'b0, 32'd0, 1'b0, lat);
      chk("evict_mem_done", 32'(exp_mem.size()), 32'd0);
      chk("miss_cnt_2", miss_cnt, 32'd2);
      chk("hit_cnt_replay", hit_cnt, 32'd3);
      do_req(1'b0, 32'h4011, 32'h0, 1'b1, 32'h1234_5678, 1'b0, lat);
      do_req(1'b0, 32'h4012, 32'h0, 1'b1, 32'h4012, 1'b0, lat);
      chk("hit_cnt_5", hit_cnt, 32'd5);

      // Back to tag 0: victim address comes from the shadow tag (1).
      m.wr = 1; m.addr = 32'h4010; m.w1 = 32'h1234_5678; exp_mem.push_back(m);
      m.wr = 0; m.addr = 32'h10; m.w1 = 0; exp_mem.push_back(m);
      do_req(1'b0, 32'h11, 32'h0, 1'b1, 32'h11, 1'b0, lat);
      chk("shadow_mem_done", 32'(exp_mem.size()), 32'd0);
      chk("miss_cnt_3", miss_cnt, 32'd3);

      // Slow fill held, then reset mid-fill.
      mem_delay = 20;
      m.wr = 0; m.addr = 32'h200; m.w1 = 0; exp_mem.push_back(m);
      @(negedge clk);
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h200; cpu_wdata = 0;
      n = 0;
      while (!mem_rd && n < 20) begin @(negedge clk); n++; end
      chk("fill_started", 32'(mem_rd), 32'd1);
      repeat (10) begin
         @(negedge clk);
         chk("fill_hold_rd", 32'(mem_rd), 32'd1);
         chk("fill_no_done", 32'(cpu_done), 32'd0);
      end
      #2 rst = 1'b0; cpu_req = 1'b0;
      #1;
      chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
      chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
      chk("midrst_cache_en", 32'(cache_en), 32'd0);
      chk("midrst_hit_cnt", hit_cnt, 32'd0);
      chk("midrst_miss_cnt", miss_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b1; mem_delay = 0;
      repeat (2) @(negedge clk);
      chk("after_rst_idle", 32'(mem_rd | cache_en | cpu_done), 32'd0);
      chk("fill_mem_q_empty", 32'(exp_mem.size()), 32'd0);

      // Replay forced to miss: err set, single done pulse, back to idle.
      force_miss = 1'b1;
      m.wr = 0; m.addr = 32'h300; m.w1 = 0; exp_mem.push_back(m);
      d0 = done_cnt;
      do_req(1'b0, 32'h300, 32'h0, 1'b1, 32'd0, 1'b1, lat);
      force_miss = 1'b0;
      chk("err_set", 32'(err), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("err_idle", 32'(cache_en | mem_rd | mem_wr | cpu_done), 32'd0);
      end
      chk("err_done_once", 32'(done_cnt - d0), 32'd1);
      chk("err_sticky", 32'(err), 32'd1);
      chk("err_hit_cnt", hit_cnt, 32'd0);
      chk("cpu_q_empty", 32'(exp_cpu.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
